// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch side of the single-stage core.
// Owns the PC, the retired-instruction counter and the req/ack handshake
// to instruction memory. Each fetched word is held on ins until retire.
// Optional feature macro: MISALIGN_TRAP_EN (trap on misaligned redirect
// instead of silently clearing target[1:0]).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        pcsel,
  input  logic [31:0] target,
  output logic [31:0] retire_cnt,
  output logic        misalign_err
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERROR} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_inc;
  logic [31:0] target_aligned;
  logic [31:0] pc_next;
`ifdef MISALIGN_TRAP_EN
  logic        err_q, err_d;
  logic        target_misaligned;
`endif

  // Sequential successor and word-aligned redirect address.
  always_comb begin
    pc_inc         = pc_q + 32'd4;
    target_aligned = target & ~32'h0000_0003;
    pc_next        = pcsel ? target_aligned : pc_inc;
  end

`ifdef MISALIGN_TRAP_EN
  // Only a taken redirect can fault; sequential flow is always aligned.
  always_comb begin
    target_misaligned = pcsel && (target[1:0] != 2'b00);
  end
`endif

  // Next-state logic: request/hold/retire sequencing.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    cnt_d   = cnt_q;
`ifdef MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ins_d   = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          cnt_d = cnt_q + 32'd1;
          ins_d = NOP_WORD;
`ifdef MISALIGN_TRAP_EN
          if (target_misaligned) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            pc_d    = pc_next;
            state_d = FETCH;
          end
`else
          pc_d    = pc_next;
          state_d = FETCH;
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      ERROR: begin
        state_d = ERROR;
      end
`endif
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ins_q   <= NOP_WORD;
      cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      cnt_q   <= cnt_d;
`ifdef MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Request and valid are pure state decodes, so both change exactly on
  // the edge that enters or leaves FETCH/HOLD.
  always_comb begin
    imem_req   = (state_q == FETCH);
    ins_valid  = (state_q == HOLD);
    imem_addr  = pc_q;
    pc         = pc_q;
    pc_plus4   = pc_inc;
    ins        = ins_q;
    retire_cnt = cnt_q;
`ifdef MISALIGN_TRAP_EN
    misalign_err = err_q;
`else
    misalign_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit. Each table row gives
// the inputs held across one rising edge and the outputs expected after it.
// Build with +define+MISALIGN_TRAP_EN to exercise the trap variant.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        pcsel;
  logic [31:0] target;
  logic [31:0] retire_cnt;
  logic        misalign_err;

  int unsigned checks;
  int unsigned failures;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .retire       (retire),
    .pcsel        (pcsel),
    .target       (target),
    .retire_cnt   (retire_cnt),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ret;
    logic        psel;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_ins;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic ret,
                              logic psel, logic [31:0] tgt, logic e_req,
                              logic [31:0] e_pc, logic e_valid,
                              logic [31:0] e_ins, logic [31:0] e_cnt);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ret = ret; v.psel = psel; v.tgt = tgt;
    v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_ins = e_ins; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata,
                       input logic ret, input logic psel,
                       input logic [31:0] tgt);
    imem_ack = ack; imem_rdata = rdata; retire = ret; pcsel = psel; target = tgt;
  endtask

  task automatic chk_all(input string tag, input logic e_req,
                         input logic [31:0] e_pc, input logic e_valid,
                         input logic [31:0] e_ins, input logic [31:0] e_cnt,
                         input logic e_err);
    chk({tag, ".req"},   {31'd0, imem_req},  {31'd0, e_req});
    chk({tag, ".addr"},  imem_addr,          e_pc);
    chk({tag, ".pc"},    pc,                 e_pc);
    chk({tag, ".pc4"},   pc_plus4,           e_pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, ins_valid}, {31'd0, e_valid});
    chk({tag, ".ins"},   ins,                e_ins);
    chk({tag, ".cnt"},   retire_cnt,         e_cnt);
    chk({tag, ".err"},   {31'd0, misalign_err}, {31'd0, e_err});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            ack rdata         ret psel tgt            req pc            v  ins           cnt
    tbl[0]  = mk(1, 32'h0000_DEAD, 1, 0, 32'h0,         1, 32'h0,         0, NOP,          0); // BOOT ignores ack/retire
    tbl[1]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, NOP,          0);
    tbl[2]  = mk(1, 32'h0010_0093, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0010_0093, 0); // 2-cycle ack
    tbl[3]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0010_0093, 0);
    tbl[4]  = mk(1, 32'h0000_FFFF, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0010_0093, 0); // ack w/o req
    tbl[5]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         0, NOP,          1);
    tbl[6]  = mk(1, 32'h0020_0113, 0, 0, 32'h0,         0, 32'h4,         1, 32'h0020_0113, 1); // zero-latency
    tbl[7]  = mk(0, 32'h0,         1, 1, 32'h10,        1, 32'h10,        0, NOP,          2);
    tbl[8]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        0, NOP,          2);
    tbl[9]  = mk(0, 32'h0,         1, 1, 32'h400,       1, 32'h10,        0, NOP,          2); // retire in FETCH
    tbl[10] = mk(1, 32'h0030_0193, 0, 0, 32'h0,         0, 32'h10,        1, 32'h0030_0193, 2);
    tbl[11] = mk(0, 32'h0,         1, 1, 32'h100,       1, 32'h100,       0, NOP,          3); // redirect
    tbl[12] = mk(1, 32'h0040_0213, 0, 0, 32'h0,         0, 32'h100,       1, 32'h0040_0213, 3);
    tbl[13] = mk(0, 32'h0,         1, 0, 32'h800,       1, 32'h104,       0, NOP,          4); // target ignored
    tbl[14] = mk(1, 32'h0050_0293, 0, 0, 32'h0,         0, 32'h104,       1, 32'h0050_0293, 4);
    tbl[15] = mk(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, NOP,          5);
    tbl[16] = mk(1, 32'h0060_0313, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0060_0313, 5);
    tbl[17] = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         0, NOP,          6); // wrap to 0
    tbl[18] = mk(1, 32'h0070_0393, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0070_0393, 6);

    rst = 1'b1;
    drive(0, '0, 0, 0, '0);
    step();
    step();
    chk_all("reset", 0, 32'h0, 0, NOP, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].ret, tbl[i].psel, tbl[i].tgt);
      step();
      chk_all($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_pc,
              tbl[i].e_valid, tbl[i].e_ins, tbl[i].e_cnt, 0);
    end

    // Stall: HOLD with retire low must keep everything frozen.
    drive(0, '0, 0, 1, 32'h200);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("stall%0d.req", i), {31'd0, imem_req}, 32'd0);
      chk($sformatf("stall%0d.pc", i), pc, 32'h0);
      chk($sformatf("stall%0d.ins", i), ins, 32'h0070_0393);
    end

    // Misaligned redirect.
    drive(0, '0, 1, 1, 32'h0000_0102);
    step();
`ifdef MISALIGN_TRAP_EN
    chk_all("mis", 0, 32'h0, 0, NOP, 7, 1);
    drive(1, 32'h1234_5678, 1, 1, 32'h40);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("err%0d", i), 0, 32'h0, 0, NOP, 7, 1);
    end
`else
    chk_all("mis", 1, 32'h100, 0, NOP, 7, 0);
    drive(1, 32'h0080_0413, 0, 0, '0);
    step();
    chk_all("mis.fetch", 0, 32'h100, 1, 32'h0080_0413, 7, 0);
    drive(0, '0, 1, 0, '0);
    step();
    chk_all("mis.seq", 1, 32'h104, 0, NOP, 8, 0);
`endif

    // Reset taken while requesting (or trapped): all back to reset values.
    drive(1, 32'hAAAA_5555, 1, 1, 32'h300);
    rst = 1'b1;
    step();
    chk_all("rst2", 0, 32'h0, 0, NOP, 0, 0);
    rst = 1'b0;
    drive(0, '0, 0, 0, '0);
    step();
    chk_all("boot2", 1, 32'h0, 0, NOP, 0, 0);

    // Reset asserted during a plain FETCH: request drops on the next edge.
    rst = 1'b1;
    step();
    chk_all("rst3", 0, 32'h0, 0, NOP, 0, 0);
    rst = 1'b0;
    step();
    chk_all("boot3", 1, 32'h0, 0, NOP, 0, 0);
    drive(1, 32'h0090_0493, 0, 0, '0);
    step();
    chk_all("fetch3", 0, 32'h0, 1, 32'h0090_0493, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch side of the single-stage core. Feeds the decode/control logic through the instruction word interface, and consumes its pcsel decision plus the ALU-computed jump/branch target to choose the next PC.
- Owns the PC register, a retired-instruction counter and the req/ack handshake to instruction memory.
- Holds each instruction word stable until the datapath signals retire.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_WORD, 32'h0000_0013, value driven on ins while no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equals pc
imem_ack  input  1  memory response strobe, rdata valid this cycle
imem_rdata  input  32  fetched instruction word
ins  output  32  instruction word to control unit/decoder
ins_valid  output  1  ins holds a fetched instruction
pc  output  32  address of the current instruction
pc_plus4  output  32  pc + 4, for JAL/JALR link writeback
retire  input  1  datapath finished the current instruction
pcsel  input  1  1 = redirect to target, 0 = sequential
target  input  32  redirect address (ALU result)
retire_cnt  output  32  number of retired instructions
misalign_err  output  1  sticky misaligned-target flag (optional feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; all state updates occur on the rising clk edge.
- Reset values:
  - pc=RESET_PC; ins=NOP_WORD; ins_valid=0; imem_req=0; retire_cnt=0; misalign_err=0.
  - State=BOOT.
- States: BOOT, FETCH, HOLD, ERROR (ERROR exists only with the optional feature).
- BOOT: one cycle with no request, then FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc are held stable until imem_ack is sampled high.
  - On ack: ins<=imem_rdata, ins_valid<=1, imem_req<=0, go to HOLD.
  - An ack in the first cycle of req is legal, giving a minimum fetch latency of 1 cycle from req to ins_valid.
- HOLD:
  - ins and pc are held stable.
  - On retire=1:
    - pc<=pcsel ? aligned(target) : pc+4.
    - retire_cnt<=retire_cnt+1.
    - ins_valid<=0 and ins<=NOP_WORD.
    - Go to FETCH; imem_req rises on the cycle after retire.
- pc_plus4: combinational pc+4.
- Arithmetic wraps modulo 2^32:
  - pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
  - retire_cnt wraps 32'hFFFF_FFFF -> 0.
- Ignored inputs:
  - retire in BOOT, FETCH or ERROR is ignored.
  - imem_ack while imem_req=0 is ignored.
  - pcsel and target are sampled only with retire in HOLD.
- Simultaneous events:
  - rst has priority over everything.
  - rst during FETCH abandons the request: req low on the next edge. Instruction memory must drop any pending response on reset.
- aligned(target) without the optional feature: {target[31:2],2'b00}.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - On retire with pcsel=1 and target[1:0]!=0: pc is unchanged, misalign_err<=1, go to ERROR.
  - ERROR issues no requests, holds ins_valid=0 and ins=NOP_WORD, and is left only by rst.
  - retire_cnt still increments for the faulting instruction.
- Undefined: misalign_err tied 0, target low two bits cleared as above, no ERROR state.

Test Plan:
- Reset then sequential: RESET_PC=0, memory acks each req after 2 cycles, retire 1 cycle after each ins_valid -> imem_addr sequence 0x0,0x4,0x8; ins matches rdata; retire_cnt=3 after three retires.
- Zero-latency memory: ack in the same cycle as req -> ins_valid on the next edge; req deasserted that edge; one fetch per retire, no duplicate requests.
- Redirect: in HOLD at pc=0x10, retire with pcsel=1, target=0x0000_0100 -> next imem_addr=0x100; pc_plus4=0x104 after update; pcsel=0 case gives 0x14.
- Stall and ignore: hold retire low 10 cycles in HOLD -> ins and pc unchanged, no req. Pulse ack and retire during BOOT -> no state change.
- Wrap and reset: pc=0xFFFF_FFFC, retire pcsel=0 -> pc=0. Assert rst mid-FETCH -> req low next edge; all outputs at reset values; BOOT then req at RESET_PC.
- Misaligned target: retire, pcsel=1, target=0x102.
  - With MISALIGN_TRAP_EN: misalign_err=1, no further req, pc stays; misalign_err clears only on rst.
  - Without: next imem_addr=0x100, misalign_err=0.
